// File: rtl/issue_select_pkg.sv
// Package: issue_select_pkg
// Shared sizes, packet types and the CDB wakeup helper for the issue stage.
//   N         issue lanes and CDB tags per cycle
//   RS_SZ     reservation-station entries scanned per cycle
//   B_MASK_W  width of the branch mask carried by every instruction
// Types:
//   RS_PACKET       one RS entry payload (sources, ready bits, branch mask)
//   CDB_ETB_PACKET  one tag broadcast on the CDB
//   ISSUE_PACKET    RS payload plus the lane it was placed in
//   ISSUE_DEBUG     ready vector, pick vector and stall (DEBUG builds only)
package issue_select_pkg;

  localparam int N        = 3;
  localparam int RS_SZ    = 8;
  localparam int TAG_W    = 6;
  localparam int B_MASK_W = 4;
  localparam int OPC_W    = 8;
  localparam int LANE_W   = $clog2(N);

  typedef logic [B_MASK_W-1:0] B_MASK_MASK;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [TAG_W-1:0] dest_tag;
    logic [TAG_W-1:0] source1;
    logic             source1_ready;
    logic [TAG_W-1:0] source2;
    logic             source2_ready;
    B_MASK_MASK       b_mask;
  } RS_PACKET;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } CDB_ETB_PACKET;

  typedef struct packed {
    RS_PACKET          rs;
    logic [LANE_W-1:0] lane;
  } ISSUE_PACKET;

  typedef struct packed {
    logic [RS_SZ-1:0] ready;
    logic [RS_SZ-1:0] pick;
    logic             stall;
  } ISSUE_DEBUG;

  // A source counts as ready if the RS already marked it, or if its tag is
  // being broadcast on the CDB this very cycle.
  function automatic logic src_is_ready(input logic rdy,
                                        input logic [TAG_W-1:0] tag,
                                        input CDB_ETB_PACKET etb [N]);
    src_is_ready = rdy;
    for (int i = 0; i < N; i++) begin
      if (etb[i].valid && (etb[i].tag == tag)) begin
        src_is_ready = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/issue_select_pick.sv
// Pick logic for the issue stage: two interchangeable selectors.
//   psel_gen          lowest-index-first, REQS one-hot grants out of WIDTH requests
//     req      in   [WIDTH-1:0]           requesting entries
//     gnt_bus  out  [REQS][WIDTH-1:0]     grant k is the k-th lowest set request
//   issue_age_matrix  oldest-first, used only when ISSUE_AGE_PRIORITY_EN is defined
//     clock, reset   in   clock and async active-high reset
//     alloc          in   [RS_SZ-1:0]  entries newly allocated this cycle
//     free           in   [RS_SZ-1:0]  entries issuing or squashed this cycle
//     req            in   [RS_SZ-1:0]  ready entries
//     gnt_bus        out  [N][RS_SZ-1:0] oldest-first one-hot grants
module psel_gen #(
  parameter int WIDTH = 8,
  parameter int REQS  = 1
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt_bus [REQS]
);

  logic [WIDTH-1:0] remaining;

  // Peel the lowest set request off one grant at a time; each grant removes
  // its bit so no entry can be granted twice.
  always_comb begin
    remaining = req;
    for (int k = 0; k < REQS; k++) begin
      gnt_bus[k] = remaining & (~remaining + WIDTH'(1));
      remaining  = remaining & ~gnt_bus[k];
    end
  end

endmodule

module issue_age_matrix
  import issue_select_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [RS_SZ-1:0] alloc,
  input  logic [RS_SZ-1:0] free,
  input  logic [RS_SZ-1:0] req,
  output logic [RS_SZ-1:0] gnt_bus [N]
);

  // older_q[i][j] set means entry i is older than entry j.
  logic [RS_SZ-1:0] older_q   [RS_SZ];
  logic [RS_SZ-1:0] older_eff [RS_SZ];
  logic [RS_SZ-1:0] remaining;
  logic             blocked;

  // An entry allocated this cycle has not reached the matrix yet, so fold it
  // in here: it is younger than every existing entry and ties with the other
  // entries allocated alongside it.
  always_comb begin
    for (int i = 0; i < RS_SZ; i++) begin
      for (int j = 0; j < RS_SZ; j++) begin
        if (i == j)        older_eff[i][j] = 1'b0;
        else if (alloc[i]) older_eff[i][j] = 1'b0;
        else if (alloc[j]) older_eff[i][j] = 1'b1;
        else               older_eff[i][j] = older_q[i][j];
      end
    end
  end

  // Each grant takes the remaining request that nobody else blocks; i blocks
  // j when it is older, or when they tie and i has the lower index.
  always_comb begin
    remaining = req;
    blocked   = 1'b0;
    for (int k = 0; k < N; k++) begin
      gnt_bus[k] = '0;
      for (int j = 0; j < RS_SZ; j++) begin
        blocked = 1'b0;
        for (int i = 0; i < RS_SZ; i++) begin
          if ((i != j) && remaining[i] &&
              (older_eff[i][j] || (!older_eff[j][i] && (i < j)))) begin
            blocked = 1'b1;
          end
        end
        if (remaining[j] && !blocked && (gnt_bus[k] == '0)) begin
          gnt_bus[k][j] = 1'b1;
        end
      end
      remaining = remaining & ~gnt_bus[k];
    end
  end

  // Commit the folded-in allocations and wipe the row and column of any entry
  // that leaves the RS, so a reused slot starts without stale ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RS_SZ; i++) older_q[i] <= '0;
    end else begin
      for (int i = 0; i < RS_SZ; i++) begin
        for (int j = 0; j < RS_SZ; j++) begin
          older_q[i][j] <= (free[i] || free[j]) ? 1'b0 : older_eff[i][j];
        end
      end
    end
  end

endmodule

// File: rtl/issue_select.sv
// Module: issue_select
// Issue stage behind the reservation station. Each cycle it picks up to N
// ready RS entries (CDB wakeup included), reports them back to the RS on
// rs_data_issuing and registers them into compacted issue lanes. Lanes hold
// under ex_stall while branch resolution keeps clearing/squashing them.
// Build options:
//   ISSUE_AGE_PRIORITY_EN  oldest-first selection via issue_age_matrix
//                          (undefined: lowest index first via psel_gen)
//   DEBUG                  adds the issue_debug output
// Ports:
//   clock, reset     clock; async active-high reset
//   rs_data          RS contents, one packet per entry
//   rs_valid         RS valid after mispredict squash
//   ETB_tags         tags broadcast on the CDB this cycle
//   b_mm_resolve     branch bit being resolved this cycle
//   b_mm_mispred     resolving branch mispredicted
//   ex_stall         execute cannot accept new lanes this cycle
//   rs_data_issuing  entries leaving the RS this cycle (combinational)
//   issue_packets    registered issue lanes
//   issue_valid      lane k holds a live instruction
module issue_select
  import issue_select_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  RS_PACKET         rs_data [RS_SZ],
  input  logic [RS_SZ-1:0] rs_valid,
  input  CDB_ETB_PACKET    ETB_tags [N],
  input  B_MASK_MASK       b_mm_resolve,
  input  logic             b_mm_mispred,
  input  logic             ex_stall,
  output logic [RS_SZ-1:0] rs_data_issuing,
  output ISSUE_PACKET      issue_packets [N],
  output logic [N-1:0]     issue_valid
`ifdef DEBUG
  ,
  output ISSUE_DEBUG       issue_debug
`endif
);

  logic [RS_SZ-1:0] ready;
  logic [RS_SZ-1:0] pick_all;
  logic [RS_SZ-1:0] gnt_bus [N];
  ISSUE_PACKET      load_pkt [N];
  logic [N-1:0]     load_valid;
  RS_PACKET         sel;
  logic             hit;

  // An entry is ready when it is valid and both sources are ready, counting
  // tags that arrive on the CDB this same cycle.
  always_comb begin
    ready = '0;
    for (int j = 0; j < RS_SZ; j++) begin
      ready[j] = rs_valid[j] &
                 src_is_ready(rs_data[j].source1_ready, rs_data[j].source1, ETB_tags) &
                 src_is_ready(rs_data[j].source2_ready, rs_data[j].source2, ETB_tags);
    end
  end

`ifdef ISSUE_AGE_PRIORITY_EN
  logic [RS_SZ-1:0] rs_valid_q;
  logic [RS_SZ-1:0] alloc;
  logic [RS_SZ-1:0] free;

  // Issued entries are dropped from the registered copy so that an RS slot
  // refilled right after issuing still shows up as a fresh allocation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rs_valid_q <= '0;
    else       rs_valid_q <= rs_valid & ~rs_data_issuing;
  end

  assign alloc = rs_valid & ~rs_valid_q;
  assign free  = rs_data_issuing | (rs_valid_q & ~rs_valid);

  issue_age_matrix u_age (
    .clock   (clock),
    .reset   (reset),
    .alloc   (alloc),
    .free    (free),
    .req     (ready),
    .gnt_bus (gnt_bus)
  );
`else
  psel_gen #(
    .WIDTH (RS_SZ),
    .REQS  (N)
  ) u_psel (
    .req     (ready),
    .gnt_bus (gnt_bus)
  );
`endif

  // Nothing leaves the RS while execute is stalled or the stage is in reset;
  // otherwise every granted entry is reported.
  always_comb begin
    pick_all = '0;
    for (int k = 0; k < N; k++) pick_all = pick_all | gnt_bus[k];
    rs_data_issuing = (reset || ex_stall) ? '0 : pick_all;
  end

  // Build the packet each lane would load: the granted entry with both
  // sources marked ready and the resolving branch bit already cleared. A
  // pick that depends on a branch mispredicting right now loads as invalid.
  always_comb begin
    sel        = '0;
    hit        = 1'b0;
    load_valid = '0;
    for (int k = 0; k < N; k++) begin
      sel = '0;
      for (int j = 0; j < RS_SZ; j++) begin
        if (gnt_bus[k][j]) sel = rs_data[j];
      end
      hit               = |(sel.b_mask & b_mm_resolve);
      sel.source1_ready = 1'b1;
      sel.source2_ready = 1'b1;
      sel.b_mask        = sel.b_mask & ~b_mm_resolve;
      load_pkt[k].rs    = sel;
      load_pkt[k].lane  = LANE_W'(k);
      load_valid[k]     = (|gnt_bus[k]) & ~(b_mm_mispred & hit);
    end
  end

  // Lanes reload every unstalled cycle. Under stall they hold, but branch
  // resolution still clears mask bits and a mispredict still kills lanes
  // that depend on it; a killed lane stays empty until the stall ends.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issue_valid <= '0;
      for (int k = 0; k < N; k++) issue_packets[k] <= '0;
    end else if (!ex_stall) begin
      issue_valid <= load_valid;
      for (int k = 0; k < N; k++) issue_packets[k] <= load_pkt[k];
    end else begin
      for (int k = 0; k < N; k++) begin
        issue_packets[k].rs.b_mask <= issue_packets[k].rs.b_mask & ~b_mm_resolve;
        issue_valid[k] <= issue_valid[k] &
                          ~(b_mm_mispred & (|(issue_packets[k].rs.b_mask & b_mm_resolve)));
      end
    end
  end

`ifdef DEBUG
  // Snapshot of this cycle's selection for debug visibility.
  always_comb begin
    issue_debug.ready = ready;
    issue_debug.pick  = pick_all;
    issue_debug.stall = ex_stall;
  end
`endif

endmodule

// File: tb/tb_issue_select.sv
// Testbench: tb_issue_select
// Directed vectors for issue_select. Stimulus pushes hand-computed expected
// values, tagged with the cycle they belong to, into a scoreboard queue; a
// monitor on the falling edge pops and compares them against the DUT.
module tb_issue_select;
  import issue_select_pkg::*;

  logic             clock;
  logic             reset;
  RS_PACKET         rs_data [RS_SZ];
  logic [RS_SZ-1:0] rs_valid;
  CDB_ETB_PACKET    ETB_tags [N];
  B_MASK_MASK       b_mm_resolve;
  logic             b_mm_mispred;
  logic             ex_stall;
  logic [RS_SZ-1:0] rs_data_issuing;
  ISSUE_PACKET      issue_packets [N];
  logic [N-1:0]     issue_valid;
`ifdef DEBUG
  ISSUE_DEBUG       issue_debug;
`endif

  typedef struct {
    int          cyc;
    int          kind;
    int          lane;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  localparam int K_ISSUING = 0;
  localparam int K_VALID   = 1;
  localparam int K_OPC     = 2;
  localparam int K_BMASK   = 3;
  localparam int K_SRCRDY  = 4;
  localparam int K_PKTZERO = 5;
  localparam int K_LANE    = 6;

  issue_select dut (
    .clock           (clock),
    .reset           (reset),
    .rs_data         (rs_data),
    .rs_valid        (rs_valid),
    .ETB_tags        (ETB_tags),
    .b_mm_resolve    (b_mm_resolve),
    .b_mm_mispred    (b_mm_mispred),
    .ex_stall        (ex_stall),
    .rs_data_issuing (rs_data_issuing),
    .issue_packets   (issue_packets),
    .issue_valid     (issue_valid)
`ifdef DEBUG
    ,
    .issue_debug     (issue_debug)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Advance to just after the next rising edge and drive a fresh RS image:
  // entry j carries opcode j, ready sources and an empty branch mask.
  task automatic applyStimulus(input logic [RS_SZ-1:0] valid_vec, input logic stall,
                               input logic [B_MASK_W-1:0] resolve, input logic mispred);
    @(posedge clock);
    #1;
    for (int j = 0; j < RS_SZ; j++) begin
      rs_data[j] = '{opcode: OPC_W'(j), dest_tag: TAG_W'(j + 32), source1: TAG_W'(j),
                     source1_ready: 1'b1, source2: TAG_W'(j + 8), source2_ready: 1'b1,
                     b_mask: '0};
    end
    for (int i = 0; i < N; i++) ETB_tags[i] = '{valid: 1'b0, tag: '0};
    rs_valid     = valid_vec;
    ex_stall     = stall;
    b_mm_resolve = resolve;
    b_mm_mispred = mispred;
  endtask

  task automatic push_exp(input int delay, input int kind, input int lane,
                          input logic [31:0] val, input string name);
    exp_t it;
    it.cyc  = cyc + delay;
    it.kind = kind;
    it.lane = lane;
    it.exp  = val;
    it.name = name;
    sb.push_back(it);
  endtask

  // Expected lane contents after the next rising edge: the valid vector plus
  // the source entry (opcode) of every lane expected to be valid.
  task automatic expectLanes(input string name, input logic [N-1:0] valid,
                             input int o0, input int o1, input int o2);
    int opc [N];
    opc[0] = o0; opc[1] = o1; opc[2] = o2;
    push_exp(1, K_VALID, 0, 32'(valid), {name, "_valid"});
    for (int k = 0; k < N; k++) begin
      if (valid[k]) push_exp(1, K_OPC, k, 32'(opc[k]), {name, "_opc"});
    end
  endtask

  function automatic logic [31:0] actual_of(input int kind, input int lane);
    case (kind)
      K_ISSUING: actual_of = 32'(rs_data_issuing);
      K_VALID:   actual_of = 32'(issue_valid);
      K_OPC:     actual_of = 32'(issue_packets[lane].rs.opcode);
      K_BMASK:   actual_of = 32'(issue_packets[lane].rs.b_mask);
      K_SRCRDY:  actual_of = {30'd0, issue_packets[lane].rs.source1_ready,
                              issue_packets[lane].rs.source2_ready};
      K_PKTZERO: actual_of = 32'(issue_packets[lane] == '0);
      K_LANE:    actual_of = 32'(issue_packets[lane].lane);
      default:   actual_of = '1;
    endcase
  endfunction

  // Pop every expectation due this cycle; anything older was missed.
  task automatic checkOutput();
    exp_t        it;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      it = sb.pop_front();
      vectors++;
      if (it.cyc < cyc) begin
        miscompares++;
        $display("[TB] FAIL %s: expectation for cycle %0d not checked (now %0d)",
                 it.name, it.cyc, cyc);
      end else begin
        act = actual_of(it.kind, it.lane);
        if (act !== it.exp) begin
          miscompares++;
          $display("[TB] FAIL %s lane%0d: got 'h%0h, want 'h%0h",
                   it.name, it.lane, act, it.exp);
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      checkOutput();
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    rs_valid     = '0;
    ex_stall     = 1'b0;
    b_mm_resolve = '0;
    b_mm_mispred = 1'b0;
    for (int j = 0; j < RS_SZ; j++) rs_data[j] = '0;
    for (int i = 0; i < N; i++) ETB_tags[i] = '0;

    // Reset holds everything off even with a full, ready RS.
    applyStimulus(8'hFF, 1'b0, '0, 1'b0);
    push_exp(0, K_ISSUING, 0, 32'h0, "rst_issuing");
    push_exp(0, K_VALID,   0, 32'h0, "rst_valid");
    push_exp(0, K_PKTZERO, 0, 32'h1, "rst_pkt0");
    applyStimulus(8'h00, 1'b0, '0, 1'b0);
    reset = 1'b0;

    // Four ready, three lanes: lowest three go, entry 6 waits.
    applyStimulus(8'b0110_0110, 1'b0, '0, 1'b0);
    push_exp(0, K_ISSUING, 0, 32'b0010_0110, "t1_issuing");
    expectLanes("t1", 3'b111, 1, 2, 5);
    push_exp(1, K_LANE, 2, 32'd2, "t1_lane_idx");
    applyStimulus(8'b0100_0000, 1'b0, '0, 1'b0);
    push_exp(0, K_ISSUING, 0, 32'b0100_0000, "t1b_issuing");
    expectLanes("t1b", 3'b001, 6, 0, 0);
    applyStimulus(8'h00, 1'b0, '0, 1'b0);
    push_exp(0, K_ISSUING, 0, 32'h0, "zero_issuing");
    expectLanes("zero", 3'b000, 0, 0, 0);

    // Same-cycle CDB wakeup; a matching tag marked invalid does not wake.
    applyStimulus(8'b1001_0000, 1'b0, '0, 1'b0);
    rs_data[4].source1_ready = 1'b0;
    rs_data[4].source1       = 6'd13;
    rs_data[7].source2_ready = 1'b0;
    rs_data[7].source2       = 6'd20;
    ETB_tags[0] = '{valid: 1'b1, tag: 6'd13};
    ETB_tags[1] = '{valid: 1'b0, tag: 6'd20};
    ETB_tags[2] = '{valid: 1'b1, tag: 6'd21};
    push_exp(0, K_ISSUING, 0, 32'b0001_0000, "t2_issuing");
    expectLanes("t2", 3'b001, 4, 0, 0);
    push_exp(1, K_SRCRDY, 0, 32'b11, "t2_srcrdy");
    applyStimulus(8'h00, 1'b0, '0, 1'b0);

    // Stall holds lanes and blocks issue; release issues the waiting pair.
    applyStimulus(8'b1001_0100, 1'b0, '0, 1'b0);
    push_exp(0, K_ISSUING, 0, 32'b1001_0100, "t3a_issuing");
    expectLanes("t3a", 3'b111, 2, 4, 7);
    applyStimulus(8'b0000_1001, 1'b1, '0, 1'b0);
    push_exp(0, K_ISSUING, 0, 32'h0, "t3_stall_issuing");
    expectLanes("t3_hold", 3'b111, 2, 4, 7);
    applyStimulus(8'b0000_1001, 1'b0, '0, 1'b0);
    push_exp(0, K_ISSUING, 0, 32'b0000_1001, "t3_go_issuing");
    expectLanes("t3_go", 3'b011, 0, 3, 0);

    // Held lane squashed by a mispredict, then not refilled while stalled.
    applyStimulus(8'b0010_0000, 1'b0, '0, 1'b0);
    rs_data[5].b_mask = 4'b0100;
    expectLanes("t4_load", 3'b001, 5, 0, 0);
    push_exp(1, K_BMASK, 0, 32'b0100, "t4_load_bmask");
    applyStimulus(8'h00, 1'b1, 4'b0100, 1'b1);
    push_exp(1, K_VALID, 0, 32'b000, "t4_squash_valid");
    applyStimulus(8'b0000_0010, 1'b1, '0, 1'b0);
    push_exp(0, K_ISSUING, 0, 32'h0, "t4_stall_issuing");
    push_exp(1, K_VALID, 0, 32'b000, "t4_norefill_valid");
    // Correct prediction on a held lane just clears the mask bit.
    applyStimulus(8'b0100_0000, 1'b0, '0, 1'b0);
    rs_data[6].b_mask = 4'b0100;
    push_exp(0, K_ISSUING, 0, 32'b0100_0000, "t4b_issuing");
    applyStimulus(8'h00, 1'b1, 4'b0100, 1'b0);
    expectLanes("t4_keep", 3'b001, 6, 0, 0);
    push_exp(1, K_BMASK, 0, 32'b0000, "t4_keep_bmask");

    // Load and mispredict in the same cycle: the dependent pick loads invalid.
    applyStimulus(8'b0000_0110, 1'b0, 4'b0010, 1'b1);
    rs_data[1].b_mask = 4'b0010;
    rs_data[2].b_mask = 4'b0001;
    push_exp(0, K_ISSUING, 0, 32'b0000_0110, "t4c_issuing");
    expectLanes("t4c", 3'b010, 0, 2, 0);
    push_exp(1, K_BMASK, 1, 32'b0001, "t4c_bmask");
    applyStimulus(8'b0000_1000, 1'b0, 4'b1000, 1'b0);
    rs_data[3].b_mask = 4'b1010;
    expectLanes("t4d", 3'b001, 3, 0, 0);
    push_exp(1, K_BMASK, 0, 32'b0010, "t4d_bmask");

    // Entries arrive one at a time (7, then 0, then 3) while stalled.
    applyStimulus(8'h00, 1'b0, '0, 1'b0);
    applyStimulus(8'b1000_0000, 1'b1, '0, 1'b0);
    applyStimulus(8'b1000_0001, 1'b1, '0, 1'b0);
    applyStimulus(8'b1000_1001, 1'b1, '0, 1'b0);
    push_exp(0, K_ISSUING, 0, 32'h0, "t5_stall_issuing");
    applyStimulus(8'b1000_1001, 1'b0, '0, 1'b0);
    push_exp(0, K_ISSUING, 0, 32'b1000_1001, "t5_issuing");
`ifdef ISSUE_AGE_PRIORITY_EN
    expectLanes("t5_age", 3'b111, 7, 0, 3);
`else
    expectLanes("t5_idx", 3'b111, 0, 3, 7);
`endif

    // Mid-cycle asynchronous reset with live lanes.
    applyStimulus(8'b0000_0111, 1'b0, '0, 1'b0);
    push_exp(0, K_ISSUING, 0, 32'b0000_0111, "t6_issuing");
    applyStimulus(8'b0000_0111, 1'b1, '0, 1'b0);
    push_exp(0, K_VALID, 0, 32'b111, "t6_live_valid");
    applyStimulus(8'b0000_0111, 1'b0, '0, 1'b0);
    #2;
    reset = 1'b1;
    push_exp(0, K_ISSUING, 0, 32'h0, "t6_rst_issuing");
    push_exp(0, K_VALID,   0, 32'h0, "t6_rst_valid");
    push_exp(0, K_PKTZERO, 1, 32'h1, "t6_rst_pkt1");
    applyStimulus(8'b0000_0111, 1'b0, '0, 1'b0);
    push_exp(0, K_ISSUING, 0, 32'h0, "t6_held_issuing");
    applyStimulus(8'b0000_0111, 1'b0, '0, 1'b0);
    reset = 1'b0;
    push_exp(0, K_ISSUING, 0, 32'b0000_0111, "t6_after_issuing");
    expectLanes("t6_after", 3'b111, 0, 1, 2);

    applyStimulus(8'h00, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
